// File: rtl/sram_fifo_ctrl_if.sv
// Core-side push/pop channel of sram_fifo_ctrl: valid/ready push, FWFT pop, occupancy.
// slave = FIFO side, master = producer/consumer side.
interface sram_fifo_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [7:0]        level_o;

    modport slave (
        input  wr_data_i, wr_valid_i, rd_ready_i,
        output wr_ready_o, rd_data_o, rd_valid_o, level_o
    );

    modport master (
        output wr_data_i, wr_valid_i, rd_ready_i,
        input  wr_ready_o, rd_data_o, rd_valid_o, level_o
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// 128-deep FIFO controller over a 1W/1R 128xDATA_W SRAM with a 2-entry FWFT output buffer.
// Optional macro SRAM_FIFO_BYPASS_EN: pushes into an empty FIFO skip the SRAM (1-cycle latency).
module sram_fifo_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sram_fifo_ctrl_if.slave   core_if,
    output logic [6:0]        sram_a1_o,
    output logic [DATA_W-1:0] sram_i1_o,
    output logic              sram_csb1_o,
    output logic              sram_web1_o,
    output logic              sram_oeb1_o,
    output logic [6:0]        sram_a2_o,
    output logic              sram_csb2_o,
    output logic              sram_web2_o,
    output logic              sram_oeb2_o,
    input  logic [DATA_W-1:0] sram_o2_i
);
    localparam logic [7:0] SRAM_DEPTH = 8'd128;

    logic [6:0]        wptr_q, wptr_d;
    logic [6:0]        rptr_q, rptr_d;
    logic [7:0]        sram_cnt_q, sram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        obuf_cnt_q, obuf_cnt_d;
    logic [DATA_W-1:0] obuf_head_q, obuf_head_d;
    logic [DATA_W-1:0] obuf_tail_q, obuf_tail_d;

    logic              wr_ready;
    logic              push;
    logic              pop;
    logic              issue;
    logic              bypass;
    logic              to_sram;
    logic [1:0]        keep_cnt;
    logic [DATA_W-1:0] fill_word;

    always_comb begin : ctl
        wr_ready = (sram_cnt_q < SRAM_DEPTH);
        push     = core_if.wr_valid_i & wr_ready & ~rst_i;
        pop      = core_if.rd_ready_i & (obuf_cnt_q != 2'd0) & ~rst_i;
        keep_cnt = obuf_cnt_q - {1'b0, pop};
        // Issue only if the word landing next cycle is guaranteed a buffer slot.
        issue    = ~rst_i & (sram_cnt_q != 8'd0)
                 & (({1'b0, keep_cnt} + {2'b00, inflight_q}) < 3'd2);
`ifdef SRAM_FIFO_BYPASS_EN
        bypass   = push & (sram_cnt_q == 8'd0) & ~inflight_q & (keep_cnt < 2'd2);
`else
        bypass   = 1'b0;
`endif
        to_sram  = push & ~bypass;
    end

    assign fill_word = inflight_q ? sram_o2_i : core_if.wr_data_i;

    always_comb begin : nxt
        wptr_d      = wptr_q + {6'd0, to_sram};
        rptr_d      = rptr_q + {6'd0, issue};
        sram_cnt_d  = sram_cnt_q + {7'd0, to_sram} - {7'd0, issue};
        inflight_d  = issue;
        obuf_cnt_d  = keep_cnt;
        obuf_head_d = pop ? obuf_tail_q : obuf_head_q;
        obuf_tail_d = obuf_tail_q;
        // Capture and bypass are mutually exclusive: bypass requires an empty pipe.
        if (inflight_q || bypass) begin
            if (keep_cnt == 2'd0) begin
                obuf_head_d = fill_word;
            end else begin
                obuf_tail_d = fill_word;
            end
            obuf_cnt_d = keep_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            sram_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            obuf_cnt_q  <= '0;
            obuf_head_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            sram_cnt_q  <= sram_cnt_d;
            inflight_q  <= inflight_d;
            obuf_cnt_q  <= obuf_cnt_d;
            obuf_head_q <= obuf_head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        obuf_tail_q <= obuf_tail_d;
    end

    assign core_if.wr_ready_o = wr_ready;
    assign core_if.rd_data_o  = obuf_head_q;
    assign core_if.rd_valid_o = (obuf_cnt_q != 2'd0);
    assign core_if.level_o    = sram_cnt_q + {7'd0, inflight_q} + {6'd0, obuf_cnt_q};

    assign sram_a1_o   = wptr_q;
    assign sram_i1_o   = core_if.wr_data_i;
    assign sram_csb1_o = ~to_sram;
    assign sram_web1_o = 1'b0;
    assign sram_oeb1_o = 1'b1;
    assign sram_a2_o   = rptr_q;
    assign sram_csb2_o = ~issue;
    assign sram_web2_o = 1'b1;
    assign sram_oeb2_o = 1'b0;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: queue-level FIFO model checked every cycle, plus directed literal checks.
module tb_sram_fifo_ctrl;
`ifdef SRAM_FIFO_BYPASS_EN
    localparam int BYP = 1;
    localparam int LAT = 1;
    localparam int LVL = 1;
`else
    localparam int BYP = 0;
    localparam int LAT = 3;
    localparam int LVL = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.DATA_W(32)) bus ();

    logic [6:0]  a1, a2;
    logic [31:0] i1;
    logic [31:0] o2;
    logic        csb1, web1, oeb1, csb2, web2, oeb2;

    sram_fifo_ctrl #(.DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core_if     (bus),
        .sram_a1_o   (a1),
        .sram_i1_o   (i1),
        .sram_csb1_o (csb1),
        .sram_web1_o (web1),
        .sram_oeb1_o (oeb1),
        .sram_a2_o   (a2),
        .sram_csb2_o (csb2),
        .sram_web2_o (web2),
        .sram_oeb2_o (oeb2),
        .sram_o2_i   (o2)
    );

    // Behavioural two-port SRAM macro.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (!csb1) mem[a1] <= i1;
        if (!csb2) o2 <= mem[a2];
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: words live in one of three places -- SRAM, the read pipe, the output buffer.
    logic [31:0] m_sram[$];
    logic [31:0] m_pipe[$];
    logic [31:0] m_obuf[$];
    logic [31:0] got[$];
    int m_wptr = 0;
    int m_rptr = 0;
    int m_acc  = 0;

    function automatic void mdl_ctl(output bit push, output bit pop, output bit issue, output bit byp);
        int keep;
        push  = bus.wr_valid_i && (m_sram.size() < 128);
        pop   = bus.rd_ready_i && (m_obuf.size() != 0);
        keep  = m_obuf.size() - (pop ? 1 : 0);
        issue = (m_sram.size() != 0) && ((keep + m_pipe.size()) < 2);
        byp   = (BYP != 0) && push && (m_sram.size() == 0) && (m_pipe.size() == 0) && (keep < 2);
    endfunction

    always @(posedge clk) begin
        bit p, q, is, by;
        logic [31:0] w;
        if (rst) begin
            m_sram.delete();
            m_pipe.delete();
            m_obuf.delete();
            m_wptr = 0;
            m_rptr = 0;
        end else begin
            mdl_ctl(p, q, is, by);
            if (q) void'(m_obuf.pop_front());
            if (m_pipe.size() != 0) begin
                w = m_pipe.pop_front();
                m_obuf.push_back(w);
            end
            if (is) begin
                w = m_sram.pop_front();
                m_pipe.push_back(w);
                m_rptr = (m_rptr + 1) % 128;
            end
            if (p) begin
                m_acc++;
                if (by) m_obuf.push_back(bus.wr_data_i);
                else begin
                    m_sram.push_back(bus.wr_data_i);
                    m_wptr = (m_wptr + 1) % 128;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit p, q, is, by;
        if (chk_en && !rst) begin
            mdl_ctl(p, q, is, by);
            chk("wr_ready", 32'(bus.wr_ready_o), 32'(m_sram.size() < 128));
            chk("rd_valid", 32'(bus.rd_valid_o), 32'(m_obuf.size() != 0));
            chk("level", 32'(bus.level_o), 32'(m_sram.size() + m_pipe.size() + m_obuf.size()));
            if (m_obuf.size() != 0) chk("rd_data", bus.rd_data_o, m_obuf[0]);
            chk("csb1", 32'(csb1), 32'(!(p && !by)));
            if (p && !by) chk("a1", 32'(a1), 32'(m_wptr));
            chk("csb2", 32'(csb2), 32'(!is));
            if (is) chk("a2", 32'(a2), 32'(m_rptr));
            if (bus.rd_valid_o && bus.rd_ready_i) got.push_back(bus.rd_data_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        bus.wr_valid_i = 1'b0;
        bus.rd_ready_i = 1'b1;
        n = 0;
        while (bus.level_o != 8'd0 && n < 400) begin
            step();
            n++;
        end
        chk({nm, "_drained"}, 32'(bus.level_o), 32'd0);
    endtask

    initial begin
        int n, base;
        rst = 1'b1;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_ready_i = 1'b0;

        // Reset: two cycles.
        step();
        step();
        chk("rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
        chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("rst_rd_data", bus.rd_data_o, 32'd0);
        chk("rst_level", 32'(bus.level_o), 32'd0);
        chk("rst_csb1", 32'(csb1), 32'd1);
        chk("rst_csb2", 32'(csb2), 32'd1);
        chk("tie_offs", {28'd0, web1, oeb1, web2, oeb2}, 32'b0110);
        rst = 1'b0;
        chk_en = 1;
        step();

        // Single word latency.
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'hDEADBEEF;
        bus.rd_ready_i = 1'b1;
        step();
        bus.wr_valid_i = 1'b0;
        n = 1;
        while (!bus.rd_valid_o && n < 10) begin
            step();
            n++;
        end
        chk("single_latency", 32'(n), 32'(LAT));
        chk("single_data", bus.rd_data_o, 32'hDEADBEEF);
        step();
        chk("single_level0", 32'(bus.level_o), 32'd0);
        chk("single_valid0", 32'(bus.rd_valid_o), 32'd0);

        // Fill with consumer stalled: 130 accepted, then back-pressure.
        bus.rd_ready_i = 1'b0;
        for (int i = 0; i < 136; i++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 32'(i);
            step();
        end
        bus.wr_valid_i = 1'b0;
        chk("fill_level", 32'(bus.level_o), 32'd130);
        chk("fill_wr_ready", 32'(bus.wr_ready_o), 32'd0);
        got.delete();
        drain("fill");
        chk("fill_count", 32'(got.size()), 32'd130);
        for (int i = 0; i < 130 && i < got.size(); i++) chk("fill_order", got[i], 32'(i));

        // Wrap: 300 words with irregular valid/ready.
        got.delete();
        base = m_acc;
        for (int c = 0; c < 3000 && (m_acc - base) < 300; c++) begin
            bus.wr_valid_i = ((c % 4) != 3);
            bus.wr_data_i  = 32'h1000 + 32'(m_acc - base);
            bus.rd_ready_i = ((c % 7) < 4);
            step();
        end
        chk("wrap_accepted", 32'(m_acc - base), 32'd300);
        drain("wrap");
        chk("wrap_count", 32'(got.size()), 32'd300);
        for (int i = 0; i < 300 && i < got.size(); i++) chk("wrap_order", got[i], 32'h1000 + 32'(i));

        // Streaming: push and pop every cycle.
        bus.wr_valid_i = 1'b1;
        bus.rd_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.wr_data_i = 32'h2000 + 32'(c);
            step();
            if (c >= 5) begin
                chk("stream_level", 32'(bus.level_o), 32'(LVL));
                chk("stream_valid", 32'(bus.rd_valid_o), 32'd1);
            end
        end
        drain("stream");

        // Reset mid-stream at level 50.
        bus.rd_ready_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 32'h3000 + 32'(i);
            step();
        end
        bus.wr_valid_i = 1'b0;
        chk("mid_level50", 32'(bus.level_o), 32'd50);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("mid_rst_level", 32'(bus.level_o), 32'd0);
        rst = 1'b0;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'h1234;
        bus.rd_ready_i = 1'b1;
        step();
        bus.wr_valid_i = 1'b0;
        n = 1;
        while (!bus.rd_valid_o && n < 10) begin
            step();
            n++;
        end
        chk("mid_first_valid", 32'(bus.rd_valid_o), 32'd1);
        chk("mid_first_data", bus.rd_data_o, 32'h1234);
        drain("mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Synchronous 128-deep, 32-bit FIFO controller that owns a two-port 128x32 SRAM macro (port 1 write-only, port 2 read-only) and presents valid/ready push and pop interfaces to the core-side logic. It sits directly upstream of the SRAM: it generates addresses, chip selects, write enables and output enables, and captures SRAM read data into a 2-entry output buffer so the consumer sees first-word-fall-through data at full throughput.

## Interface
- clk_i  in  1  system clock; same net drives SRAM CE1/CE2 at top level
- rst_i  in  1  synchronous, active-high reset
- wr_data_i  in  32  push data
- wr_valid_i  in  1  push request
- wr_ready_o  out  1  SRAM holds fewer than 128 entries; reset 1
- rd_data_o  out  32  head word; reset 0
- rd_valid_o  out  1  head word valid; reset 0
- rd_ready_i  in  1  consumer accepts head word
- level_o  out  8  total occupancy (SRAM + in-flight + output buffer), 0..130; reset 0
- sram_a1_o  out  7  port-1 address = write pointer; reset 0
- sram_i1_o  out  32  port-1 write data = wr_data_i
- sram_csb1_o  out  1  port-1 select, low on push; reset 1
- sram_web1_o  out  1  tied 0
- sram_oeb1_o  out  1  tied 1
- sram_a2_o  out  7  port-2 address = read pointer; reset 0
- sram_csb2_o  out  1  port-2 select, low on read issue; reset 1
- sram_web2_o  out  1  tied 1
- sram_oeb2_o  out  1  tied 0
- sram_o2_i  in  32  port-2 read data

## Operation
- push = wr_valid_i & wr_ready_o; pop = rd_valid_o & rd_ready_i.
- SRAM port controls are combinational from registered state and push/issue, stable before the clock edge at which the SRAM samples them.
- Push: sram_csb1_o=0, write at wptr; at edge wptr+=1 (7-bit wrap 127->0), sram_cnt+=1.
- Read issue: issue = (sram_cnt>0) & (obuf_cnt + inflight - pop < 2). sram_csb2_o=0 at rptr; at edge rptr+=1 (wrap), sram_cnt-=1, inflight<=1.
- Capture: cycle after issue, sram_o2_i is written into the output buffer tail; inflight cleared unless another issue occurs.
- Output buffer: 2 entries, in order; rd_data_o/rd_valid_o driven from head register.
- Simultaneous push and issue on the same edge: sram_cnt unchanged. Reads only target entries committed at earlier edges, so port 1 and port 2 never address the same word at the same edge.
- Push when wr_ready_o=0 or pop when rd_valid_o=0: ignored, no state change.
- level_o = sram_cnt + inflight + obuf_cnt, updated every edge.
- rst_i mid-operation: pointers, counts, inflight, buffer cleared at next edge; all data discarded; SRAM contents left undefined.

## Timing
- Without bypass: push at edge N -> issue at N+1 -> capture at N+2; rd_valid_o high after edge N+2 (3-cycle latency).
- Sustained throughput: 1 push and 1 pop per cycle once primed; no bubbles with rd_ready_i held high.
- wr_ready_o deasserts the cycle after the 128th un-issued word is committed; reasserts the cycle after an issue.
- Consumer back-pressure: at most 2 words outside SRAM; issue stalls until a slot is guaranteed.

## Configuration
- SRAM_FIFO_BYPASS_EN defined: when sram_cnt==0, inflight==0 and the output buffer has a free slot after this cycle's pop, push is written directly into the output buffer, SRAM not touched (sram_csb1_o stays 1); latency 1 cycle (rd_valid_o high after push edge). Ordering preserved because bypass only when SRAM and pipe are empty.
- Undefined: every push goes through SRAM; fixed 3-cycle latency.

## Test plan
- Reset: assert rst_i 2 cycles -> wr_ready_o=1, rd_valid_o=0, level_o=0, sram_csb1_o=sram_csb2_o=1.
- Single word: push 0xDEADBEEF, rd_ready_i=1 -> rd_data_o=0xDEADBEEF valid after 3 edges (1 with SRAM_FIFO_BYPASS_EN), level_o returns to 0.
- Fill: rd_ready_i=0, push 0..135 continuously -> wr_ready_o falls after 130 words accepted (128 SRAM + 2 buffer), level_o=130; drain gives 0..129 in order.
- Wrap: 300 words streamed with random rd_ready_i/wr_valid_i -> output matches input order, pointers wrap past 127 with no loss or duplication.
- Streaming: push and pop every cycle for 200 cycles -> no bubbles after priming, level_o constant.
- Reset mid-stream: rst_i with level_o=50 -> next cycle rd_valid_o=0, level_o=0; subsequent push 0x1234 returns 0x1234 first.
